// File: rtl/fetch_queue.sv
// Fetch queue: runs ahead of dispatch with one outstanding icache request, predicts the next PC
// and buffers up to DEPTH predecoded instructions. Optional macro: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int                ADDR_W   = 17,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        flush_pc,
  output logic                     icache_req_en,
  output logic [ADDR_W-1:0]        icache_req_addr,
  input  logic                     icache_rsp_en,
  input  logic [31:0]              icache_rsp_inst,
  input  logic                     icache_rsp_cinst,
  output logic [ADDR_W-1:0]        bp_query_addr,
  input  logic                     bp_taken,
  input  logic [ADDR_W-1:0]        ras_top,
  input  logic                     dispatch_ready,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic                     out_cinst,
  output logic [ADDR_W-1:0]        out_pc,
  output logic                     out_br_taken,
  output logic [ADDR_W-1:0]        out_jalr_target,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ISSUE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;

  logic [31:0]       inst_mem_q  [DEPTH];
  logic              cinst_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic              bt_mem_q    [DEPTH];
  logic [ADDR_W-1:0] ras_mem_q   [DEPTH];

  logic              head_valid_s, bypass_s, push_s, pop_s;
  logic [ADDR_W-1:0] next_pc_s;

  function automatic logic [ADDR_W-1:0] predict_pc(
    input logic [31:0]       inst,
    input logic              cinst,
    input logic              taken,
    input logic [ADDR_W-1:0] pc,
    input logic [ADDR_W-1:0] ras
  );
    logic [31:0]       b_imm;
    logic [31:0]       j_imm;
    logic [ADDR_W-1:0] len;
    b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    len   = cinst ? ADDR_W'(2) : ADDR_W'(4);
    case (inst[6:0])
      7'b1100011: predict_pc = taken ? pc + b_imm[ADDR_W-1:0] : pc + len;
      7'b1101111: predict_pc = pc + j_imm[ADDR_W-1:0];
      7'b1100111: predict_pc = ras;
      default:    predict_pc = pc + len;
    endcase
  endfunction

  assign head_valid_s = (count_q != CW'(0));
`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_s = !flush && !head_valid_s && (state_q == WAIT) && icache_rsp_en;
`else
  assign bypass_s = 1'b0;
`endif
  // A bypassed response that is consumed immediately never touches the storage.
  assign push_s    = !flush && (state_q == WAIT) && icache_rsp_en && !(bypass_s && dispatch_ready);
  assign pop_s     = !flush && head_valid_s && dispatch_ready;
  assign next_pc_s = predict_pc(icache_rsp_inst, icache_rsp_cinst, bp_taken, fetch_pc_q, ras_top);
  assign count_d   = flush ? CW'(0) : count_q + CW'(push_s) - CW'(pop_s);
  assign head_d    = flush ? PW'(0) : head_q + PW'(pop_s);
  assign tail_d    = flush ? PW'(0) : tail_q + PW'(push_s);

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    icache_req_en   = 1'b0;
    icache_req_addr = fetch_pc_q;
    if (flush) begin
      fetch_pc_d = flush_pc;
      state_d    = (state_q != ISSUE && !icache_rsp_en) ? DROP : ISSUE;
    end else begin
      case (state_q)
        ISSUE: begin
          if (count_q < CW'(DEPTH)) begin
            icache_req_en = 1'b1;
            state_d       = WAIT;
          end else begin
            state_d = ISSUE;
          end
        end
        WAIT: begin
          if (icache_rsp_en) begin
            fetch_pc_d = next_pc_s;
            if (count_d < CW'(DEPTH)) begin
              icache_req_en   = 1'b1;
              icache_req_addr = next_pc_s;
            end else begin
              state_d = ISSUE;
            end
          end else begin
            state_d = WAIT;
          end
        end
        DROP: begin
          if (icache_rsp_en) begin
            state_d = ISSUE;
          end else begin
            state_d = DROP;
          end
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ISSUE;
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push_s) begin
      inst_mem_q[tail_q]  <= icache_rsp_inst;
      cinst_mem_q[tail_q] <= icache_rsp_cinst;
      pc_mem_q[tail_q]    <= fetch_pc_q;
      bt_mem_q[tail_q]    <= bp_taken;
      ras_mem_q[tail_q]   <= ras_top;
    end
  end

  always_comb begin
    out_valid       = head_valid_s | bypass_s;
    out_inst        = '0;
    out_cinst       = 1'b0;
    out_pc          = '0;
    out_br_taken    = 1'b0;
    out_jalr_target = '0;
    if (bypass_s) begin
      out_inst        = icache_rsp_inst;
      out_cinst       = icache_rsp_cinst;
      out_pc          = fetch_pc_q;
      out_br_taken    = bp_taken;
      out_jalr_target = ras_top;
    end else if (head_valid_s) begin
      out_inst        = inst_mem_q[head_q];
      out_cinst       = cinst_mem_q[head_q];
      out_pc          = pc_mem_q[head_q];
      out_br_taken    = bt_mem_q[head_q];
      out_jalr_target = ras_mem_q[head_q];
    end else begin
      out_valid = 1'b0;
    end
  end

  assign bp_query_addr = fetch_pc_q;
  assign count         = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue: an icache model drives responses and a queue-based
// reference model predicts requests, head outputs and occupancy every cycle.
module tb_fetch_queue;

  localparam int AW    = 17;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
  logic          icache_req_en;
  logic [AW-1:0] icache_req_addr;
  logic          icache_rsp_en = 1'b0;
  logic [31:0]   icache_rsp_inst = '0;
  logic          icache_rsp_cinst = 1'b0;
  logic [AW-1:0] bp_query_addr;
  logic          bp_taken = 1'b0;
  logic [AW-1:0] ras_top = '0;
  logic          dispatch_ready = 1'b0;
  logic          out_valid;
  logic [31:0]   out_inst;
  logic          out_cinst;
  logic [AW-1:0] out_pc;
  logic          out_br_taken;
  logic [AW-1:0] out_jalr_target;
  logic [2:0]    count;

  fetch_queue #(.ADDR_W(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
    .icache_req_en(icache_req_en), .icache_req_addr(icache_req_addr),
    .icache_rsp_en(icache_rsp_en), .icache_rsp_inst(icache_rsp_inst),
    .icache_rsp_cinst(icache_rsp_cinst), .bp_query_addr(bp_query_addr),
    .bp_taken(bp_taken), .ras_top(ras_top), .dispatch_ready(dispatch_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_cinst(out_cinst), .out_pc(out_pc),
    .out_br_taken(out_br_taken), .out_jalr_target(out_jalr_target), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   inst;
    logic          cinst;
    logic [AW-1:0] pc;
    logic          bt;
    logic [AW-1:0] ras;
  } ent_t;

  ent_t          mq[$];
  logic [AW-1:0] m_pc;
  bit            m_out, m_disc;
  logic [AW-1:0] m_out_pc;

  bit ic_pend;
  int ic_wait;
  int ready_pct, flush_pct, max_lat, mode;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] ref_next(input logic [31:0] inst, input logic c,
                                             input logic t, input logic [AW-1:0] pc,
                                             input logic [AW-1:0] ras);
    int imm;
    int len;
    len = c ? 2 : 4;
    case (inst[6:0])
      7'h63: begin
        imm = inst[31] ? -4096 : 0;
        imm += int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        return t ? AW'(int'(pc) + imm) : AW'(int'(pc) + len);
      end
      7'h6f: begin
        imm = inst[31] ? -(1 << 20) : 0;
        imm += int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
        return AW'(int'(pc) + imm);
      end
      7'h67:   return ras;
      default: return AW'(int'(pc) + len);
    endcase
  endfunction

  function automatic logic [31:0] gen_inst(input int md);
    logic [31:0] w;
    int k;
    w = $urandom;
    k = (md == 0) ? 0 : $urandom_range(4);
    case (k)
      0:       w[6:0] = 7'h13;
      1:       w[6:0] = 7'h63;
      2:       w[6:0] = 7'h6f;
      3:       w[6:0] = 7'h67;
      default: w[6:0] = w[6:0];
    endcase
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc     = '0;
    m_out    = 0;
    m_disc   = 0;
    m_out_pc = '0;
    ic_pend  = 0;
    ic_wait  = 0;
  endtask

  task automatic run_cycle();
    int            sz;
    bit            exp_req, byp, push, pop;
    logic [AW-1:0] exp_addr, npc;
    ent_t          e_new, h;
    // drive this cycle's inputs
    flush          = ($urandom_range(99) < flush_pct);
    flush_pc       = AW'($urandom);
    dispatch_ready = ($urandom_range(99) < ready_pct);
    bp_taken       = (mode == 0) ? 1'b0 : 1'($urandom_range(1));
    ras_top        = AW'($urandom);
    if (ic_pend && ic_wait == 0) begin
      icache_rsp_en    = 1'b1;
      icache_rsp_inst  = gen_inst(mode);
      icache_rsp_cinst = (mode == 0) ? 1'b0 : 1'($urandom_range(1));
      ic_pend          = 0;
    end else begin
      icache_rsp_en    = 1'b0;
      icache_rsp_inst  = $urandom;
      icache_rsp_cinst = 1'($urandom_range(1));
      if (ic_pend) ic_wait--;
    end
    @(negedge clk);
    sz       = mq.size();
    exp_req  = 0;
    exp_addr = '0;
    byp      = 0;
    push     = 0;
    pop      = 0;
    npc      = '0;
    e_new    = '{icache_rsp_inst, icache_rsp_cinst, m_out_pc, bp_taken, ras_top};
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = !flush && sz == 0 && m_out && !m_disc && icache_rsp_en;
`endif
    if (!flush) begin
      pop = (sz > 0) && dispatch_ready;
      if (m_out && icache_rsp_en && !m_disc) begin
        push = !(byp && dispatch_ready);
        npc  = ref_next(icache_rsp_inst, icache_rsp_cinst, bp_taken, m_out_pc, ras_top);
        if (sz + int'(push) - int'(pop) < DEPTH) begin
          exp_req  = 1;
          exp_addr = npc;
        end
      end else if (!m_out && sz < DEPTH) begin
        exp_req  = 1;
        exp_addr = m_pc;
      end
    end
    chk("req_en", 64'(icache_req_en), 64'(exp_req));
    if (exp_req) chk("req_addr", 64'(icache_req_addr), 64'(exp_addr));
    chk("count", 64'(count), 64'(sz));
    chk("out_valid", 64'(out_valid), 64'((sz > 0) || byp));
    if (m_out && !m_disc) chk("bp_query", 64'(bp_query_addr), 64'(m_out_pc));
    if (sz > 0 || byp) begin
      h = byp ? e_new : mq[0];
      chk("out_inst", 64'(out_inst), 64'(h.inst));
      chk("out_cinst", 64'(out_cinst), 64'(h.cinst));
      chk("out_pc", 64'(out_pc), 64'(h.pc));
      chk("out_br_taken", 64'(out_br_taken), 64'(h.bt));
      chk("out_jalr_target", 64'(out_jalr_target), 64'(h.ras));
    end
    // advance the reference model to the next cycle
    if (flush) begin
      mq.delete();
      m_pc = flush_pc;
      if (m_out && !icache_rsp_en) m_disc = 1;
      else begin
        m_out  = 0;
        m_disc = 0;
      end
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e_new);
      if (m_out && icache_rsp_en) begin
        if (m_disc) begin
          m_out  = 0;
          m_disc = 0;
        end else if (exp_req) m_out_pc = npc;
        else begin
          m_out = 0;
          m_pc  = npc;
        end
      end else if (exp_req) begin
        m_out    = 1;
        m_out_pc = m_pc;
      end
    end
    if (icache_req_en) begin
      ic_pend = 1;
      ic_wait = $urandom_range(max_lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input int cycles, input int rdy, input int fl, input int lat, input int md);
    ready_pct = rdy;
    flush_pct = fl;
    max_lat   = lat;
    mode      = md;
    for (int i = 0; i < cycles; i++) run_cycle();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst_n = 1'b1;
    phase(40, 100, 0, 0, 0);
    phase(30, 0, 0, 0, 0);
    phase(20, 100, 0, 0, 0);
    phase(1500, 60, 3, 2, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_req_addr", 64'(icache_req_addr), 64'(0));
    rst_n = 1'b1;
    model_reset();
    phase(1000, 30, 10, 3, 1);
    phase(500, 90, 1, 1, 1);
    phase(300, 100, 20, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
